// File: rtl/gate_truth_sequencer.sv
// Walks a 2-input gate through {a,b} = 00..11, samples its output after a settle
// delay, and grades the captured truth table against EXPECT.
//
// state  | meaning
// IDLE   | waiting for start; gates parked at 00; last results held
// APPLY  | drive {a,b} = idx, load settle count
// SETTLE | count down SETTLE_CYCLES cycles for the gate output to settle
// SAMPLE | capture gate_c into result[idx], advance idx
// DONE   | one-cycle done pulse, pass/fail_mask valid
module gate_truth_sequencer #(
   parameter int           SETTLE_CYCLES = 2,
   parameter int           SETTLE_W      = 4,
   parameter logic [3:0]   EXPECT        = 4'b1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic       gate_a,
   output logic       gate_b,
   input  logic       gate_c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] result,
   output logic [3:0] fail_mask
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
   localparam logic [SETTLE_W-1:0] CNT_ONE     = SETTLE_W'(1);

   state_t              state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic                gate_a_q, gate_a_d;
   logic                gate_b_q, gate_b_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [3:0]          result_q, result_d;
   logic [3:0]          fail_mask_q, fail_mask_d;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      gate_a_d    = gate_a_q;
      gate_b_d    = gate_b_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      result_d    = result_q;
      fail_mask_d = fail_mask_q;

      if (state_q == S_IDLE) begin
         if (start && !abort) begin
            state_d     = S_APPLY;
            idx_d       = 2'd0;
            gate_a_d    = 1'b0;
            gate_b_d    = 1'b0;
            busy_d      = 1'b1;
            pass_d      = 1'b0;
            result_d    = 4'b0000;
            fail_mask_d = 4'b0000;
         end
      end else if (abort) begin
         // Rows already captured stay visible; the grade is cleared.
         state_d     = S_IDLE;
         gate_a_d    = 1'b0;
         gate_b_d    = 1'b0;
         busy_d      = 1'b0;
         pass_d      = 1'b0;
         fail_mask_d = 4'b0000;
      end else begin
         case (state_q)
            S_APPLY: begin
               cnt_d   = SETTLE_LOAD;
               state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt_q <= CNT_ONE) begin
                  state_d = S_SAMPLE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            S_SAMPLE: begin
               result_d[idx_q] = gate_c;
               if (idx_q == 2'd3) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  pass_d      = (result_d == EXPECT);
                  fail_mask_d = result_d ^ EXPECT;
               end else begin
                  state_d              = S_APPLY;
                  idx_d                = idx_q + 2'd1;
                  {gate_a_d, gate_b_d} = idx_q + 2'd1;
               end
            end
            S_DONE: begin
               state_d  = S_IDLE;
               gate_a_d = 1'b0;
               gate_b_d = 1'b0;
               busy_d   = 1'b0;
            end
            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= 2'd0;
         cnt_q       <= '0;
         gate_a_q    <= 1'b0;
         gate_b_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         result_q    <= 4'b0000;
         fail_mask_q <= 4'b0000;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         gate_a_q    <= gate_a_d;
         gate_b_q    <= gate_b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         result_q    <= result_d;
         fail_mask_q <= fail_mask_d;
      end
   end

   assign gate_a    = gate_a_q;
   assign gate_b    = gate_b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign result    = result_q;
   assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: two instances (settle 2 and settle 0) share stimulus and are
// compared every cycle against a cycle-count model of a run, plus directed literal checks.
module tb_gate_truth_sequencer;

   localparam logic [3:0] EXP = 4'b1000;
   localparam int SC0 = 2;
   localparam int SC1 = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] tt = 4'b1000;

   logic       ga[2], gb[2], gc[2], busy[2], done[2], pass[2];
   logic [3:0] res[2], fm[2];

   int checks = 0;
   int errors = 0;

   // gate under test modelled as a truth table indexed by {a,b}
   assign gc[0] = tt[{ga[0], gb[0]}];
   assign gc[1] = tt[{ga[1], gb[1]}];

   always #5 clk = ~clk;

   gate_truth_sequencer #(.SETTLE_CYCLES(SC0), .SETTLE_W(4), .EXPECT(EXP)) dut0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .gate_a(ga[0]), .gate_b(gb[0]), .gate_c(gc[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .result(res[0]), .fail_mask(fm[0])
   );

   gate_truth_sequencer #(.SETTLE_CYCLES(SC1), .SETTLE_W(4), .EXPECT(EXP)) dut1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .gate_a(ga[1]), .gate_b(gb[1]), .gate_c(gc[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .result(res[1]), .fail_mask(fm[1])
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic int len_of(input int k);
      return ((k == 0) ? SC0 : SC1) + 2;
   endfunction

   // Model: a run is a cycle number t (1 = cycle after the accepting edge).
   // Vector v occupies cycles v*len+1 .. (v+1)*len, sampled at the end of its last cycle;
   // cycle 4*len+1 is the done cycle.
   bit         m_run[2];
   int         m_t[2];
   logic [3:0] m_res[2], m_fm[2];
   logic       m_pass[2];

   always @(posedge clk or posedge rst) begin : model
      int len;
      int n;
      logic [3:0] r;
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_run[k]  <= 1'b0;
            m_t[k]    <= 0;
            m_res[k]  <= 4'b0000;
            m_fm[k]   <= 4'b0000;
            m_pass[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            len = len_of(k);
            n   = 4 * len;
            r   = m_res[k];
            if (!m_run[k]) begin
               if (start && !abort) begin
                  m_run[k]  <= 1'b1;
                  m_t[k]    <= 1;
                  m_res[k]  <= 4'b0000;
                  m_pass[k] <= 1'b0;
                  m_fm[k]   <= 4'b0000;
               end
            end else if (abort) begin
               m_run[k]  <= 1'b0;
               m_pass[k] <= 1'b0;
               m_fm[k]   <= 4'b0000;
            end else if (m_t[k] == n + 1) begin
               m_run[k] <= 1'b0;
            end else begin
               if (m_t[k] % len == 0) r[m_t[k] / len - 1] = tt[m_t[k] / len - 1];
               m_res[k] <= r;
               m_t[k]   <= m_t[k] + 1;
               if (m_t[k] + 1 == n + 1) begin
                  m_pass[k] <= (r == EXP);
                  m_fm[k]   <= r ^ EXP;
               end
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      int len;
      int n;
      int e_pair;
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            len = len_of(k);
            n   = 4 * len;
            if (!m_run[k])        e_pair = 0;
            else if (m_t[k] <= n) e_pair = (m_t[k] - 1) / len;
            else                  e_pair = 3;
            chk($sformatf("busy%0d", k), int'(busy[k]), int'(m_run[k]));
            chk($sformatf("done%0d", k), int'(done[k]), int'(m_run[k] && (m_t[k] == n + 1)));
            chk($sformatf("gates%0d", k), int'({ga[k], gb[k]}), e_pair);
            chk($sformatf("result%0d", k), int'(res[k]), int'(m_res[k]));
            chk($sformatf("pass%0d", k), int'(pass[k]), int'(m_pass[k]));
            chk($sformatf("fail_mask%0d", k), int'(fm[k]), int'(m_fm[k]));
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_gates", int'({ga[0], gb[0]}), 0);
      chk("rst_result", int'(res[0]), 0);
      chk("rst_pass", int'(pass[0]), 0);
      @(negedge clk);
      rst = 1'b0;

      // ideal AND gate
      tt = 4'b1000;
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         chk("and_done0", int'(done[0]), int'(c == 17));
         chk("and_done1", int'(done[1]), int'(c == 9));
         if (c <= 16) chk("and_pair0", int'({ga[0], gb[0]}), (c - 1) / 4);
         if (c <= 8)  chk("and_pair1", int'({ga[1], gb[1]}), (c - 1) / 2);
         if (c == 17) begin
            chk("and_result0", int'(res[0]), 8);
            chk("and_pass0", int'(pass[0]), 1);
            chk("and_fm0", int'(fm[0]), 0);
         end
         if (c == 9) begin
            chk("and_result1", int'(res[1]), 8);
            chk("and_pass1", int'(pass[1]), 1);
         end
      end

      // gate output stuck at 1
      tt = 4'b1111;
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         chk("stk_done0", int'(done[0]), int'(c == 17));
         if (c == 17) begin
            chk("stk_result0", int'(res[0]), 15);
            chk("stk_fm0", int'(fm[0]), 7);
            chk("stk_pass0", int'(pass[0]), 0);
         end
      end

      // abort during SETTLE of vector idx=2 (cycle 10)
      tt = 4'b1000;
      start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 10) abort = 1'b1;
         if (c == 11) begin
            abort = 1'b0;
            chk("abt_busy0", int'(busy[0]), 0);
            chk("abt_gates0", int'({ga[0], gb[0]}), 0);
            chk("abt_pass0", int'(pass[0]), 0);
            chk("abt_result0", int'(res[0]), 0);
         end
         if (c >= 11) chk("abt_nodone0", int'(done[0]), 0);
      end

      // start held through a whole run: one run, then immediate re-run
      start = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (c == 17) chk("hold_done0", int'(done[0]), 1);
         if (c == 18) chk("hold_idle0", int'(busy[0]), 0);
         if (c == 19) chk("hold_rerun0", int'(busy[0]), 1);
      end
      start = 1'b0;
      repeat (20) @(negedge clk);

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("sa_busy0", int'(busy[0]), 0);
         chk("sa_busy1", int'(busy[1]), 0);
      end
      start = 1'b0;
      abort = 1'b0;

      // asynchronous reset mid-SETTLE, then a clean run
      tt = 4'b1111;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_result0", int'(res[0]), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy0", int'(busy[0]), 0);
      chk("arst_gates0", int'({ga[0], gb[0]}), 0);
      chk("arst_result0", int'(res[0]), 0);
      chk("arst_done0", int'(done[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      tt = 4'b1000;
      start = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 17) begin
            chk("post_rst_done0", int'(done[0]), 1);
            chk("post_rst_pass0", int'(pass[0]), 1);
         end
      end

      // randomized stimulus, checked every cycle against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 19) == 0);
         if (!m_run[0] && !m_run[1] && $urandom_range(0, 3) == 0) tt = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
